// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM test sequencer: default widths, FSM encoding
// and the expected-data (checkerboard) function.
package sram_test_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Odd addresses carry the inverted pattern when invert_odd is set.
  // Computed at 32 bits; callers cast down to their data width (<= 32).
  function automatic logic [31:0] exp_data(input logic [31:0] pattern,
                                           input logic        invert_odd,
                                           input logic        addr_lsb);
    return pattern ^ {32{invert_odd & addr_lsb}};
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// RD_LAT-deep shift register that carries {valid, expected data} (plus the
// read address when SRAM_SEQ_ERR_LOG_EN is defined) alongside the SRAM read.
module sram_rd_pipe #(
`ifdef SRAM_SEQ_ERR_LOG_EN
  parameter int ADDR_W = 15,
`endif
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              data_clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
`ifdef SRAM_SEQ_ERR_LOG_EN
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] out_addr,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

`ifdef SRAM_SEQ_ERR_LOG_EN
  localparam int ENTRY_W = 1 + DATA_W + ADDR_W;
`else
  localparam int ENTRY_W = 1 + DATA_W;
`endif

  logic [ENTRY_W-1:0]             entry_in;
  logic [RD_LAT-1:0][ENTRY_W-1:0] pipe_reg;
  logic [RD_LAT-1:0][ENTRY_W-1:0] pipe_next;

`ifdef SRAM_SEQ_ERR_LOG_EN
  assign entry_in = push ? {1'b1, push_data, push_addr} : '0;
`else
  assign entry_in = push ? {1'b1, push_data} : '0;
`endif

  assign pipe_next[0] = entry_in;

  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_shift
    assign pipe_next[gi] = pipe_reg[gi-1];
  end

  always_ff @(posedge data_clk) begin
    if (!reset) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg <= pipe_next;
    end
  end

  assign out_valid = pipe_reg[RD_LAT-1][ENTRY_W-1];
  assign out_data  = pipe_reg[RD_LAT-1][ENTRY_W-2 -: DATA_W];
`ifdef SRAM_SEQ_ERR_LOG_EN
  assign out_addr  = pipe_reg[RD_LAT-1][ADDR_W-1:0];
`endif

endmodule

// File: rtl/sram_test_sequencer.sv
// Write sweep followed by read-back sweep over [start, end], counting mismatches.
// Define SRAM_SEQ_ERR_LOG_EN to add first-mismatch address/data capture outputs.
module sram_test_sequencer
  import sram_test_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 2,
  parameter int ERR_W  = 16
) (
  input  logic              data_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              invert_odd,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [ADDR_W-1:0] cfg_addr_start,
  input  logic [ADDR_W-1:0] cfg_addr_end,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_re,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
`ifdef SRAM_SEQ_ERR_LOG_EN
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              first_err_valid,
`endif
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [1:0]       DRAIN_END = 2'(RD_LAT - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_ptr_reg, addr_ptr_next;
  logic [ADDR_W-1:0] addr_start_reg, addr_end_reg;
  logic [DATA_W-1:0] cfg_data_reg;
  logic              invert_reg;
  logic [1:0]        drain_cnt_reg, drain_cnt_next;
  logic [ERR_W-1:0]  err_count_reg;
  logic              cfg_err_reg;

  logic              accept;
  logic              cfg_bad;
  logic              at_end;
  logic [DATA_W-1:0] exp_cur;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_exp;
  logic              mismatch;

  assign accept  = (state_reg == ST_IDLE) && start;
  assign cfg_bad = cfg_addr_end < cfg_addr_start;
  // Equality termination keeps an end of all-ones from wrapping the pointer.
  assign at_end  = addr_ptr_reg == addr_end_reg;
  assign exp_cur = DATA_W'(exp_data(32'(cfg_data_reg), invert_reg, addr_ptr_reg[0]));

  always_comb begin
    state_next     = state_reg;
    addr_ptr_next  = addr_ptr_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            state_next = ST_DONE;
          end else begin
            state_next    = ST_WRITE;
            addr_ptr_next = cfg_addr_start;
          end
        end
      end
      ST_WRITE: begin
        if (at_end) begin
          state_next    = ST_READ;
          addr_ptr_next = addr_start_reg;
        end else begin
          addr_ptr_next = addr_ptr_reg + 1'b1;
        end
      end
      ST_READ: begin
        if (at_end) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = '0;
        end else begin
          addr_ptr_next = addr_ptr_reg + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == DRAIN_END) begin
          state_next = ST_DONE;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge data_clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      addr_ptr_reg   <= '0;
      drain_cnt_reg  <= '0;
      addr_start_reg <= '0;
      addr_end_reg   <= '0;
      cfg_data_reg   <= '0;
      invert_reg     <= 1'b0;
      err_count_reg  <= '0;
      cfg_err_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_ptr_reg  <= addr_ptr_next;
      drain_cnt_reg <= drain_cnt_next;
      if (accept) begin
        addr_start_reg <= cfg_addr_start;
        addr_end_reg   <= cfg_addr_end;
        cfg_data_reg   <= cfg_data;
        invert_reg     <= invert_odd;
        err_count_reg  <= '0;
        cfg_err_reg    <= cfg_bad;
      end else if (mismatch && (err_count_reg != ERR_MAX)) begin
        err_count_reg <= err_count_reg + 1'b1;
      end
    end
  end

`ifdef SRAM_SEQ_ERR_LOG_EN
  logic [ADDR_W-1:0] pipe_addr;
  logic [ADDR_W-1:0] first_err_addr_reg;
  logic [DATA_W-1:0] first_err_data_reg;
  logic              first_err_valid_reg;

  sram_rd_pipe #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT)
  ) u_rd_pipe (
    .data_clk  (data_clk),
    .reset     (reset),
    .push      (state_reg == ST_READ),
    .push_data (exp_cur),
    .push_addr (addr_ptr_reg),
    .out_addr  (pipe_addr),
    .out_valid (pipe_valid),
    .out_data  (pipe_exp)
  );

  always_ff @(posedge data_clk) begin
    if (!reset) begin
      first_err_addr_reg  <= '0;
      first_err_data_reg  <= '0;
      first_err_valid_reg <= 1'b0;
    end else if (accept) begin
      first_err_addr_reg  <= '0;
      first_err_data_reg  <= '0;
      first_err_valid_reg <= 1'b0;
    end else if (mismatch && !first_err_valid_reg) begin
      first_err_addr_reg  <= pipe_addr;
      first_err_data_reg  <= sram_rdata;
      first_err_valid_reg <= 1'b1;
    end
  end

  assign first_err_addr  = first_err_addr_reg;
  assign first_err_data  = first_err_data_reg;
  assign first_err_valid = first_err_valid_reg;
`else
  sram_rd_pipe #(
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT)
  ) u_rd_pipe (
    .data_clk  (data_clk),
    .reset     (reset),
    .push      (state_reg == ST_READ),
    .push_data (exp_cur),
    .out_valid (pipe_valid),
    .out_data  (pipe_exp)
  );
`endif

  assign mismatch = pipe_valid && (sram_rdata != pipe_exp);

  // Pins are decoded from the registered state so we/re can never overlap.
  assign sram_addr  = addr_ptr_reg;
  assign sram_we    = state_reg == ST_WRITE;
  assign sram_re    = state_reg == ST_READ;
  assign sram_wdata = (state_reg == ST_WRITE) ? exp_cur : '0;
  assign busy       = state_reg != ST_IDLE;
  assign done       = state_reg == ST_DONE;
  assign cfg_err    = cfg_err_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Scoreboard bench for sram_test_sequencer: stimulus queues expected SRAM
// accesses and end-of-run results, a negedge monitor pops and compares them.
module tb_sram_test_sequencer;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int ERR_W  = 4;

  logic              data_clk = 1'b0;
  logic              reset;
  logic              start;
  logic              invert_odd;
  logic [DATA_W-1:0] cfg_data;
  logic [ADDR_W-1:0] cfg_addr_start;
  logic [ADDR_W-1:0] cfg_addr_end;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_we;
  logic              sram_re;
  logic [DATA_W-1:0] sram_rdata;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic [ERR_W-1:0]  err_count;
`ifdef SRAM_SEQ_ERR_LOG_EN
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;
  logic              first_err_valid;
`endif

  always #5 data_clk = ~data_clk;

  sram_test_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .ERR_W  (ERR_W)
  ) dut (
    .data_clk        (data_clk),
    .reset           (reset),
    .start           (start),
    .invert_odd      (invert_odd),
    .cfg_data        (cfg_data),
    .cfg_addr_start  (cfg_addr_start),
    .cfg_addr_end    (cfg_addr_end),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_we         (sram_we),
    .sram_re         (sram_re),
    .sram_rdata      (sram_rdata),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
`ifdef SRAM_SEQ_ERR_LOG_EN
    .first_err_addr  (first_err_addr),
    .first_err_data  (first_err_data),
    .first_err_valid (first_err_valid),
`endif
    .err_count       (err_count)
  );

  // SRAM model with optional single-address bit flip or full-word inversion on read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  logic              flip_en = 1'b0;
  logic [ADDR_W-1:0] flip_addr = '0;
  logic              inv_all = 1'b0;

  always @(posedge data_clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_re)
      rd_pipe[0] <= mem[sram_addr]
                    ^ ((flip_en && sram_addr == flip_addr) ? 8'h01 : 8'h00)
                    ^ (inv_all ? 8'hFF : 8'h00);
    else
      rd_pipe[0] <= '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata = rd_pipe[RD_LAT-1];

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int                cycles;
    logic [ERR_W-1:0]  err;
    logic              cerr;
    logic [ADDR_W-1:0] fa;
    logic [DATA_W-1:0] fd;
    logic              fv;
  } done_t;

  wr_t               wr_q [$];
  logic [ADDR_W-1:0] rd_q [$];
  done_t             done_q [$];

  int passed = 0;
  int total = 0;
  int done_seen = 0;
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    else passed++;
  endtask

  // Monitor: pops expectations whenever the DUT drives an SRAM access or done.
  always @(negedge data_clk) begin
    wr_t               w;
    logic [ADDR_W-1:0] ra;
    done_t             r;
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (sram_we || sram_re) chk("we_re_exclusive", {31'd0, sram_we & sram_re}, 32'd0);
      if (sram_we) begin
        if (wr_q.size() == 0) chk("unexpected_write", {17'd0, sram_addr}, 32'hFFFF_FFFF);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", {17'd0, sram_addr}, {17'd0, w.addr});
          chk("wr_data", {24'd0, sram_wdata}, {24'd0, w.data});
        end
      end
      if (sram_re) begin
        if (rd_q.size() == 0) chk("unexpected_read", {17'd0, sram_addr}, 32'hFFFF_FFFF);
        else begin
          ra = rd_q.pop_front();
          chk("rd_addr", {17'd0, sram_addr}, {17'd0, ra});
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          r = done_q.pop_front();
          chk("run_cycles", busy_cnt, r.cycles);
          chk("err_count", {28'd0, err_count}, {28'd0, r.err});
          chk("cfg_err", {31'd0, cfg_err}, {31'd0, r.cerr});
`ifdef SRAM_SEQ_ERR_LOG_EN
          chk("first_err", {first_err_valid, first_err_addr, first_err_data},
              {r.fv, r.fa, r.fd});
`endif
        end
        done_seen++;
        busy_cnt = 0;
      end
    end
  end

  task automatic run_test(input string tag, input logic [14:0] s, input logic [14:0] e,
                          input logic [7:0] d, input logic inv, input int cycles,
                          input logic [3:0] err, input logic cerr, input logic [14:0] fa,
                          input logic [7:0] fd, input logic fv, input bit poke);
    done_t       r;
    int          seen0;
    logic [14:0] a;
    if (!cerr) begin
      for (int i = 0; i <= int'(e - s); i++) begin
        a = s + 15'(i);
        wr_q.push_back({a, d ^ {8{inv & a[0]}}});
        rd_q.push_back(a);
      end
    end
    r = '{cycles, err, cerr, fa, fd, fv};
    done_q.push_back(r);
    seen0 = done_seen;
    @(posedge data_clk); #1;
    start = 1'b1; cfg_addr_start = s; cfg_addr_end = e; cfg_data = d; invert_odd = inv;
    @(posedge data_clk); #1;
    start = 1'b0; cfg_addr_start = 15'h1234; cfg_addr_end = 15'h0001; cfg_data = 8'h00;
    invert_odd = ~inv;
    if (poke) begin
      repeat (2) @(posedge data_clk);
      #1 start = 1'b1;
      @(posedge data_clk);
      #1 start = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      @(posedge data_clk); #1;
      start = poke && done;
      if (done_seen != seen0) break;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, done_seen - seen0, 32'd1);
    chk({tag, "_wr_left"}, wr_q.size(), 32'd0);
    chk({tag, "_rd_left"}, rd_q.size(), 32'd0);
    repeat (2) @(posedge data_clk);
    #1 chk({tag, "_hold"}, {26'd0, busy, cfg_err, err_count}, {26'd0, 1'b0, cerr, err});
    wr_q.delete(); rd_q.delete(); done_q.delete();
    $display("run %s: start=0x%04h end=0x%04h data=0x%02h inv=%0d", tag, s, e, d, inv);
  endtask

  initial begin
    int seen0;
    reset = 1'b0; start = 1'b0; invert_odd = 1'b0; cfg_data = '0;
    cfg_addr_start = '0; cfg_addr_end = '0;
    repeat (3) @(posedge data_clk);
    #1 chk("reset_outputs",
           {sram_addr, sram_wdata, sram_we, sram_re, busy, done, cfg_err, err_count}, 32'd0);
    reset = 1'b1;

    run_test("pass",    15'h0010, 15'h0013, 8'hA5, 1'b0, 11, 4'h0, 1'b0, 15'h0, 8'h00, 1'b0, 1'b0);
    run_test("checker", 15'h0000, 15'h0003, 8'h0F, 1'b1, 11, 4'h0, 1'b0, 15'h0, 8'h00, 1'b0, 1'b0);
    flip_en = 1'b1; flip_addr = 15'h0012;
    run_test("fault",   15'h0010, 15'h0013, 8'hA5, 1'b0, 11, 4'h1, 1'b0, 15'h0012, 8'hA4, 1'b1, 1'b0);
    flip_en = 1'b0;
    run_test("top_addr", 15'h7FFF, 15'h7FFF, 8'h3C, 1'b1, 5, 4'h0, 1'b0, 15'h0, 8'h00, 1'b0, 1'b0);
    run_test("cfg_err", 15'h0009, 15'h0005, 8'h11, 1'b0, 1, 4'h0, 1'b1, 15'h0, 8'h00, 1'b0, 1'b0);
    inv_all = 1'b1;
    run_test("saturate", 15'h0100, 15'h0113, 8'h3C, 1'b0, 43, 4'hF, 1'b0, 15'h0100, 8'hC3, 1'b1, 1'b0);
    inv_all = 1'b0;
    run_test("poke",    15'h0020, 15'h0025, 8'h66, 1'b1, 15, 4'h0, 1'b0, 15'h0, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of the read sweep: no done, everything back to zero.
    for (int i = 0; i < 8; i++) begin
      wr_q.push_back({15'h0030 + 15'(i), 8'h5A});
      rd_q.push_back(15'h0030 + 15'(i));
    end
    seen0 = done_seen;
    @(posedge data_clk); #1;
    start = 1'b1; cfg_addr_start = 15'h0030; cfg_addr_end = 15'h0037; cfg_data = 8'h5A;
    invert_odd = 1'b0;
    @(posedge data_clk); #1 start = 1'b0;
    for (int c = 0; c < 100 && rd_q.size() > 5; c++) @(posedge data_clk);
    chk("reset_reached_read", {31'd0, rd_q.size() <= 5}, 32'd1);
    @(posedge data_clk); #1 reset = 1'b0;
    @(posedge data_clk);
    #1 chk("midrun_reset_outputs",
           {sram_addr, sram_wdata, sram_we, sram_re, busy, done, cfg_err, err_count}, 32'd0);
`ifdef SRAM_SEQ_ERR_LOG_EN
    chk("midrun_reset_log", {first_err_valid, first_err_addr, first_err_data}, 32'd0);
`endif
    wr_q.delete(); rd_q.delete(); done_q.delete();
    reset = 1'b1;
    repeat (20) @(posedge data_clk);
    #1 chk("midrun_no_done", done_seen - seen0, 32'd0);
    chk("midrun_idle", {31'd0, busy}, 32'd0);
    $display("run reset_mid_read: aborted");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_test_sequencer.md
Name: sram_test_sequencer

Overview:
- Consumes the latched test configuration (8-bit data pattern, 15-bit start and end addresses) produced by the serial configuration loader.
- Runs one full write sweep, then one read-back sweep over the SRAM address range.
- Compares each read word against the expected pattern, counts mismatches and reports pass/fail.
- Sits between the configuration loader and the 22nm SRAM macro pins; runs on data_clk.

Parameters:
- ADDR_W, 15, SRAM address width.
- DATA_W, 8, SRAM data width.
- RD_LAT, 2, SRAM read latency in data_clk cycles from sram_re to valid sram_rdata; legal range 1..4.
- ERR_W, 16, error counter width.

Ports:
- data_clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- start  in  1  single-cycle pulse; begins a test run; sampled only in IDLE.
- invert_odd  in  1  checkerboard select; sampled with start.
- cfg_data  in  DATA_W  test pattern; sampled with start.
- cfg_addr_start  in  ADDR_W  first address; sampled with start.
- cfg_addr_end  in  ADDR_W  last address, inclusive; sampled with start.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_we  out  1  write enable, active-high.
- sram_re  out  1  read enable, active-high.
- sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after sram_re.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run.
- cfg_err  out  1  sticky until next accepted start; set when end < start.
- err_count  out  ERR_W  mismatch count; saturates at all-ones; held until next accepted start.

Behaviour:
- Reset values: all outputs 0. FSM returns to IDLE; the read pipeline and latched configuration are cleared.
- Reset mid-run aborts the run immediately. No done pulse is generated.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - On start, latch cfg_* and invert_odd, clear err_count and cfg_err.
  - If cfg_addr_end < cfg_addr_start: set cfg_err, go to DONE. No SRAM access occurs.
  - Otherwise go to WRITE with addr_ptr = start.
- Expected data: exp(a) = cfg_data XOR {DATA_W{invert_odd & a[0]}}.
- WRITE:
  - Each cycle drive sram_we=1, sram_addr=addr_ptr, sram_wdata=exp(addr_ptr).
  - If addr_ptr == end: addr_ptr = start, go to READ. Otherwise addr_ptr + 1.
- READ:
  - Each cycle drive sram_re=1, sram_addr=addr_ptr.
  - Push {valid, expected data} into an RD_LAT-deep shift pipe.
  - At addr_ptr == end, go to DRAIN.
- DRAIN: wait until the pipe is empty (RD_LAT cycles), then go to DONE.
- Compare: when the pipe output is valid and sram_rdata != expected, err_count increments; it holds at 2^ERR_W-1.
- DONE: assert done for one cycle, deassert busy, go to IDLE.
- sram_we and sram_re are never high together. Outside WRITE/READ both are 0 and sram_addr holds its last value.
- Address 0x7FFF as end terminates on equality; addr_ptr never wraps.
- start == end performs exactly 1 write and 1 read.
- Total run length for N = end − start + 1: N write + N read + RD_LAT drain + 1 DONE cycle. busy is high for exactly these cycles.
- start during busy is ignored, including start in the DONE cycle.

Optional Feature:
- Macro SRAM_SEQ_ERR_LOG_EN.
- Defined: adds outputs first_err_addr (ADDR_W), first_err_data (DATA_W) and first_err_valid (1).
  - They capture the address and read data of the first mismatch of a run.
  - They hold until the next accepted start, which clears them to 0.
  - The address travels in the read pipe alongside the expected data.
- Undefined: these ports and the address field in the pipe are absent; all other behaviour is identical.

Decomposition:
- Shared package sram_test_pkg holds:
  - ADDR_W and DATA_W defaults.
  - FSM state encoding (IDLE=0, WRITE=1, READ=2, DRAIN=3, DONE=4, 3-bit).
  - A function for the expected-data computation.
- One sub-module, sram_rd_pipe: parameterised RD_LAT-deep valid/expected(/address) shift register, instantiated once.

Test Plan:
- Pass run: start=0x0010, end=0x0013, cfg_data=0xA5, invert_odd=0, ideal SRAM model, RD_LAT=2 -> 4 writes of 0xA5 at 0x10..0x13, then 4 reads; done 11 cycles after busy rises; err_count=0.
- Checkerboard: start=0x0000, end=0x0003, cfg_data=0x0F, invert_odd=1 -> wdata 0x0F,0xF0,0x0F,0xF0; err_count=0.
- Fault injection: model flips bit 0 at address 0x0012 on read -> err_count=1; with SRAM_SEQ_ERR_LOG_EN, first_err_addr=0x0012 and first_err_data=0xA4.
- Boundary: start=end=0x7FFF -> exactly one write and one read at 0x7FFF, no wrap, done pulse. Separately, end=0x0005 with start=0x0009 -> cfg_err=1, no we/re, done 2 cycles after start.
- Saturation: ERR_W=4, model returns ~expected for 20 addresses -> err_count=0xF.
- Reset and start handling: reset low mid-READ -> next cycle all outputs 0, FSM in IDLE, no done. start pulsed while busy -> ignored, run length unchanged.
